// File: rtl/scu_dsp_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scu_dsp_dma                                                              |
// | SCU DSP D0-bus DMA engine: word handshake with the DSP, one bus cycle    |
// | per word, address writeback and DMA_END completion pulse.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module scu_dsp_dma #(
    parameter int ADDR_W  = 27,
    parameter int END_LEN = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE_R,
    input  logic [31:0]       DSO,
    input  logic              RA0W,
    input  logic              WA0W,
    input  logic              DMAW,
    input  logic              DMA_REQ,
    input  logic              DMA_WE,
    input  logic              DMA_LAST,
    input  logic [31:0]       DMA_DO,
    output logic [31:0]       DMA_DI,
    output logic              DMA_ACK,
    output logic              DMA_END,
    output logic [ADDR_W-1:0] BUS_A,
    output logic [31:0]       BUS_DO,
    input  logic [31:0]       BUS_DI,
    output logic              BUS_WE,
    output logic              BUS_REQ,
    input  logic              BUS_ACK,
    output logic              BUSY
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WAITREQ = 3'd1;
    localparam logic [2:0] c_BUSCYC  = 3'd2;
    localparam logic [2:0] c_ACK     = 3'd3;
    localparam logic [2:0] c_END     = 3'd4;
    localparam int         c_CNT_W   = $clog2(END_LEN + 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [24:0]        r_ra0;
    logic [24:0]        r_wa0;
    logic [24:0]        r_wadr;
    logic [24:0]        w_adr_sel;
    logic [6:0]         r_winc;
    logic [6:0]         w_winc;
    logic               r_hold;
    logic               r_we;
    logic               r_last;
    logic               r_first;
    logic               w_we;
    logic               w_end_done;
    logic [c_CNT_W-1:0] r_end_cnt;
    logic [31:0]        r_dma_di;
    logic [31:0]        r_bus_do;
    logic [ADDR_W-1:0]  r_bus_a;
    logic               r_bus_we;
    logic               r_bus_req;
    logic               w_unused_dso;

    assign w_unused_dso = ^DSO[31:25];

    // Word increment: byte step 1<<(ADD+1) divided by 4.
    assign w_winc     = (DSO[17:15] == 3'd0) ? 7'd0 : (7'd1 << (DSO[17:15] - 3'd1));
    // Direction and start address are taken in the first WAITREQ cycle.
    assign w_we       = r_first ? DMA_WE : r_we;
    assign w_adr_sel  = r_first ? (DMA_WE ? r_wa0 : r_ra0) : r_wadr;
    assign w_end_done = (r_end_cnt == c_CNT_W'(END_LEN - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= c_IDLE;
        end else if (CE_R) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (DMAW) w_state_nxt = c_WAITREQ;
            c_WAITREQ: if (DMA_REQ) w_state_nxt = c_BUSCYC;
            c_BUSCYC:  if (BUS_ACK) w_state_nxt = c_ACK;
            c_ACK:     w_state_nxt = r_last ? c_END : c_WAITREQ;
            c_END:     if (w_end_done) w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_ra0     <= '0;
            r_wa0     <= '0;
            r_wadr    <= '0;
            r_winc    <= '0;
            r_hold    <= 1'b0;
            r_we      <= 1'b0;
            r_last    <= 1'b0;
            r_first   <= 1'b0;
            r_end_cnt <= '0;
            r_dma_di  <= '0;
            r_bus_do  <= '0;
            r_bus_a   <= '0;
            r_bus_we  <= 1'b0;
            r_bus_req <= 1'b0;
        end else if (CE_R) begin
            case (r_state)
                c_IDLE: begin
                    if (DMAW) begin
                        r_hold  <= DSO[14];
                        r_winc  <= w_winc;
                        r_first <= 1'b1;
                    end
                end
                c_WAITREQ: begin
                    r_first <= 1'b0;
                    r_we    <= w_we;
                    r_wadr  <= w_adr_sel;
                    if (DMA_REQ) begin
                        r_bus_a   <= ADDR_W'({w_adr_sel, 2'b00});
                        r_bus_we  <= w_we;
                        r_bus_do  <= DMA_DO;
                        r_bus_req <= 1'b1;
                    end
                end
                c_BUSCYC: begin
                    if (BUS_ACK) begin
                        r_bus_req <= 1'b0;
                        if (!r_we) r_dma_di <= BUS_DI;
                        r_wadr    <= r_wadr + {18'd0, r_winc};
                        r_last    <= DMA_LAST;
                    end
                end
                c_ACK: begin
                    r_end_cnt <= '0;
                end
                c_END: begin
                    if (w_end_done) begin
                        if (!r_hold) begin
                            if (r_we) r_wa0 <= r_wadr;
                            else      r_ra0 <= r_wadr;
                        end
                    end else begin
                        r_end_cnt <= r_end_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // Placed last so a host load overrides a same-cycle writeback.
            if (RA0W) r_ra0 <= DSO[24:0];
            if (WA0W) r_wa0 <= DSO[24:0];
        end
    end

    assign DMA_DI  = r_dma_di;
    assign DMA_ACK = (r_state == c_ACK);
    assign DMA_END = (r_state == c_END);
    assign BUS_A   = r_bus_a;
    assign BUS_DO  = r_bus_do;
    assign BUS_WE  = r_bus_we;
    assign BUS_REQ = r_bus_req;
    assign BUSY    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scu_dsp_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scu_dsp_dma                                                           |
// | Directed vector table plus hand sequences for scu_dsp_dma.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_scu_dsp_dma;

    logic        CLK = 1'b0;
    logic        RST_N, CE_R, RA0W, WA0W, DMAW, DMA_REQ, DMA_WE, DMA_LAST, BUS_ACK;
    logic [31:0] DSO, DMA_DO, BUS_DI;
    logic [31:0] DMA_DI, BUS_DO;
    logic [26:0] BUS_A;
    logic        DMA_ACK, DMA_END, BUS_WE, BUS_REQ, BUSY;

    int total = 0;
    int bad   = 0;

    scu_dsp_dma #(.ADDR_W(27), .END_LEN(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .DSO(DSO),
        .RA0W(RA0W), .WA0W(WA0W), .DMAW(DMAW),
        .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_LAST(DMA_LAST),
        .DMA_DO(DMA_DO), .DMA_DI(DMA_DI), .DMA_ACK(DMA_ACK), .DMA_END(DMA_END),
        .BUS_A(BUS_A), .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .BUS_WE(BUS_WE),
        .BUS_REQ(BUS_REQ), .BUS_ACK(BUS_ACK), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // ctl = {RA0W,WA0W,DMAW,DMA_REQ,DMA_WE,DMA_LAST}; ef = {BUS_REQ,WE,DMA_ACK,DMA_END,BUSY}
    typedef struct {
        logic [5:0]  ctl;
        logic        back;
        logic [31:0] dso;
        logic [31:0] dmado;
        logic [31:0] busdi;
        logic [4:0]  ef;
        logic [26:0] ea;
        logic [31:0] edo;
        logic [31:0] edi;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] ctl, input logic back, input logic [31:0] dso,
                       input logic [31:0] dmado, input logic [31:0] busdi, input logic [4:0] ef,
                       input logic [26:0] ea, input logic [31:0] edo, input logic [31:0] edi);
        vec_t v;
        v.ctl = ctl; v.back = back; v.dso = dso; v.dmado = dmado; v.busdi = busdi;
        v.ef = ef; v.ea = ea; v.edo = edo; v.edi = edi;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        RA0W = 0; WA0W = 0; DMAW = 0; DMA_REQ = 0; DMA_WE = 0; DMA_LAST = 0;
        BUS_ACK = 0; DSO = 0; DMA_DO = 0; BUS_DI = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    initial begin
        logic [4:0]  gf;
        logic [26:0] ga;
        logic [31:0] gdo, gdi;

        idle_in();
        CE_R  = 1;
        RST_N = 0;
        tick(); tick();
        RST_N = 1;
        tick();

        chk("reset_outputs", {27'd0, BUS_REQ, BUS_WE, DMA_ACK, DMA_END, BUSY}, 32'd0);
        chk("reset_bus_a", {5'd0, BUS_A}, 32'd0);
        chk("reset_bus_do", BUS_DO, 32'd0);
        chk("reset_dma_di", DMA_DI, 32'd0);
        chk("reset_ra0", {7'd0, dut.r_ra0}, 32'd0);
        chk("reset_wa0", {7'd0, dut.r_wa0}, 32'd0);

        // 3-word read, RA0=0x100, ADD=2, HOLD=0
        add(6'b100000, 0, 32'h100,   0, 0,   5'b00000, 0,        0, 0);
        add(6'b001000, 0, 32'h10000, 0, 0,   5'b00001, 0,        0, 0);
        add(6'b000100, 0, 0,         0, 0,   5'b10001, 27'h400,  0, 0);
        add(6'b000000, 1, 0,         0, 'hA, 5'b00101, 0,        0, 'hA);
        add(6'b000100, 0, 0,         0, 0,   5'b00001, 0,        0, 0);
        add(6'b000100, 0, 0,         0, 0,   5'b10001, 27'h408,  0, 0);
        add(6'b000000, 1, 0,         0, 'hB, 5'b00101, 0,        0, 'hB);
        add(6'b000100, 0, 0,         0, 0,   5'b00001, 0,        0, 0);
        add(6'b000100, 0, 0,         0, 0,   5'b10001, 27'h410,  0, 0);
        add(6'b000001, 1, 0,         0, 'hC, 5'b00101, 0,        0, 'hC);
        add(6'b000000, 0, 0,         0, 0,   5'b00011, 0,        0, 0);
        add(6'b000000, 0, 0,         0, 0,   5'b00011, 0,        0, 0);
        add(6'b000000, 0, 0,         0, 0,   5'b00000, 0,        0, 0);
        // 2-word write, WA0=0x20, ADD=1, HOLD=1
        add(6'b010000, 0, 32'h20,    0,        0, 5'b00000, 0,       0,        0);
        add(6'b001000, 0, 32'hC000,  0,        0, 5'b00001, 0,       0,        0);
        add(6'b000110, 0, 0,  32'h1234,        0, 5'b11001, 27'h80,  32'h1234, 0);
        add(6'b000010, 1, 0,         0,        0, 5'b01101, 0,       0,        0);
        add(6'b000110, 0, 0,  32'h5678,        0, 5'b00001, 0,       0,        0);
        add(6'b000110, 0, 0,  32'h5678,        0, 5'b11001, 27'h84,  32'h5678, 0);
        add(6'b000011, 1, 0,         0,        0, 5'b01101, 0,       0,        0);
        add(6'b000010, 0, 0,         0,        0, 5'b00011, 0,       0,        0);
        add(6'b000010, 0, 0,         0,        0, 5'b00011, 0,       0,        0);
        add(6'b000000, 0, 0,         0,        0, 5'b00000, 0,       0,        0);

        for (int i = 0; i < tbl.size(); i++) begin
            {RA0W, WA0W, DMAW, DMA_REQ, DMA_WE, DMA_LAST} = tbl[i].ctl;
            BUS_ACK = tbl[i].back; DSO = tbl[i].dso; DMA_DO = tbl[i].dmado; BUS_DI = tbl[i].busdi;
            tick();
            // Bus fields only matter while a request is up; DMA_DI only on read acks.
            gf  = {BUS_REQ, (tbl[i].ef[4] ? BUS_WE : tbl[i].ef[3]), DMA_ACK, DMA_END, BUSY};
            ga  = tbl[i].ef[4] ? BUS_A  : tbl[i].ea;
            gdo = tbl[i].ef[4] ? BUS_DO : tbl[i].edo;
            gdi = (tbl[i].ef[2] && !tbl[i].ef[3]) ? DMA_DI : tbl[i].edi;
            total++;
            if ({gf, ga, gdo, gdi} !== {tbl[i].ef, tbl[i].ea, tbl[i].edo, tbl[i].edi}) begin
                bad++;
                $display("FAIL row%0d: got flags=%b a=%h do=%h di=%h expected flags=%b a=%h do=%h di=%h",
                         i, gf, ga, gdo, gdi, tbl[i].ef, tbl[i].ea, tbl[i].edo, tbl[i].edi);
            end
        end
        idle_in();
        chk("rd_ra0_writeback", {7'd0, dut.r_ra0}, 32'h106);
        chk("wr_hold_wa0", {7'd0, dut.r_wa0}, 32'h20);

        // Wrap at 2^25, delayed BUS_ACK, DMAW while busy must be ignored
        RA0W = 1; DSO = 32'h1FFFFFF; tick();
        RA0W = 0; DMAW = 1; DSO = 32'h8000; tick();
        DMAW = 0; DMA_REQ = 1; tick();
        chk("wrap_a0", {5'd0, BUS_A}, 32'h7FFFFFC);
        DMA_REQ = 0; DMAW = 1; DSO = 32'h3C000;
        for (int k = 0; k < 5; k++) begin
            tick();
            DMAW = 0;
            chk("delay_stable", {BUS_REQ, DMA_ACK, 3'd0, BUS_A}, {1'b1, 1'b0, 3'd0, 27'h7FFFFFC});
        end
        BUS_ACK = 1; BUS_DI = 32'h11; tick();
        chk("delay_ack", {BUS_REQ, DMA_ACK, DMA_DI[29:0]}, {1'b0, 1'b1, 30'h11});
        BUS_ACK = 0; DMA_REQ = 1; tick(); tick();
        chk("wrap_a1", {4'd0, BUS_REQ, BUS_A}, {4'd0, 1'b1, 27'h0});
        DMA_REQ = 0; BUS_ACK = 1; DMA_LAST = 1; BUS_DI = 32'h22; tick();
        chk("wrap_di1", DMA_DI, 32'h22);
        idle_in(); tick(); tick(); tick();
        chk("wrap_ra0", {7'd0, dut.r_ra0}, 32'h1);
        chk("wrap_idle", {31'd0, BUSY}, 32'd0);

        // Single word; RA0W mid-transfer and in the writeback cycle
        DMAW = 1; DSO = 32'h8000; tick();
        DMAW = 0; DMA_REQ = 1; tick();
        chk("single_a", {5'd0, BUS_A}, 32'h4);
        DMA_REQ = 0; BUS_ACK = 1; DMA_LAST = 1; BUS_DI = 32'h77; RA0W = 1; DSO = 32'h50; tick();
        chk("single_ack", {DMA_ACK, DMA_DI[30:0]}, {1'b1, 31'h77});
        idle_in(); tick();
        chk("end_hi0", {31'd0, DMA_END}, 32'd1);
        tick();
        chk("end_hi1", {31'd0, DMA_END}, 32'd1);
        RA0W = 1; DSO = 32'h50; tick();
        idle_in();
        chk("end_lo", {30'd0, DMA_END, BUSY}, 32'd0);
        chk("ra0w_wins", {7'd0, dut.r_ra0}, 32'h50);

        // Reset during BUSCYC, then a clean restart
        DMAW = 1; DSO = 32'h8000; tick();
        DMAW = 0; DMA_REQ = 1; tick();
        chk("pre_rst_req", {BUS_REQ, 4'd0, BUS_A}, {1'b1, 4'd0, 27'h140});
        DMA_REQ = 0; RST_N = 0; tick();
        RST_N = 1;
        chk("rst_flags", {27'd0, BUS_REQ, BUS_WE, DMA_ACK, DMA_END, BUSY}, 32'd0);
        chk("rst_bus", {BUS_DO[4:0], BUS_A}, 32'd0);
        chk("rst_di", DMA_DI, 32'd0);
        chk("rst_ra0", {7'd0, dut.r_ra0}, 32'd0);
        DMAW = 1; DSO = 32'h8000; tick();
        DMAW = 0; DMA_REQ = 1; tick();
        chk("restart_a", {BUS_REQ, 4'd0, BUS_A}, {1'b1, 4'd0, 27'h0});
        DMA_REQ = 0; BUS_ACK = 1; DMA_LAST = 1; BUS_DI = 32'h99; tick();
        chk("restart_ack", {DMA_ACK, DMA_DI[30:0]}, {1'b1, 31'h99});
        idle_in(); tick(); tick(); tick();
        chk("restart_ra0", {7'd0, dut.r_ra0}, 32'h1);
        chk("restart_idle", {31'd0, BUSY}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
